// File: rtl/blackjack_prob_engine.sv
// rtl/blackjack_prob_engine.sv - card-by-card bust / exact-21 probability engine
// Tracks the shoe histogram and per-player sums, reports probabilities in percent and the round winner.
module blackjack_prob_engine #(
   parameter int N_PLAYERS        = 2,
   parameter int CARDS_PER_PLAYER = 5,
   parameter int N_DECKS          = 1,
   parameter int ROUNDS_PER_DECK  = 5,
   localparam int PW  = ($clog2(N_PLAYERS) > 1) ? $clog2(N_PLAYERS) : 1,
   localparam int CIW = ($clog2(CARDS_PER_PLAYER) > 1) ? $clog2(CARDS_PER_PLAYER) : 1
) (
   input  logic           clk1,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [3:0]     in_card,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [PW-1:0]  out_player,
   output logic [CIW-1:0] out_card_idx,
   output logic [6:0]     out_exceed,
   output logic [6:0]     out_equal,
   output logic           out_last,
   output logic [PW:0]    out_winner,
   output logic           out_err
);

   localparam int TOT = 52 * N_DECKS;
   localparam int CW  = 7;
   localparam int TW  = 8;
   localparam int SW  = 7;
   localparam int NW  = 15;
   localparam int RMW = 16;
   localparam int RW  = ($clog2(ROUNDS_PER_DECK + 1) > 1) ? $clog2(ROUNDS_PER_DECK + 1) : 1;

   typedef enum logic [1:0] {IDLE, UPDATE, DIV, HOLD} state_t;
   state_t state_q, state_d;

   logic [3:0]        card_q;
   logic [CW-1:0]     cnt_q [1:10];
   logic [TW-1:0]     total_q;
   logic [SW-1:0]     sum_q [N_PLAYERS];
   logic [PW-1:0]     player_q;
   logic [CIW-1:0]    cidx_q;
   logic [RW-1:0]     round_q;
   logic signed [7:0] remain_q;
   logic [RMW-1:0]    rem_exc_q, rem_eq_q;
   logic [6:0]        q_exc_q, q_eq_q;
   logic [2:0]        step_q;
   logic              err_q, last_q;
   logic [PW:0]       winner_q;
   logic [6:0]        out_exc_q, out_eq_q;
   logic              out_err_q, out_last_q;
   logic [PW:0]       out_win_q;

   logic              legal;
   logic [3:0]        value;
   logic [SW-1:0]     new_sum;
   logic signed [7:0] remain_w;
   logic [CW-1:0]     cnt_new [1:10];
   logic [TW-1:0]     total_new;
   logic [TW-1:0]     exc_cnt;
   logic [CW-1:0]     eq_cnt;
   logic [NW-1:0]     num_exc, num_eq;
   logic              is_last;
   logic [PW:0]       winner_w;
   logic [SW-1:0]     best, s;
   logic              any, tie;
   logic [RMW-1:0]    dsh;
   logic              div_en;
   logic [6:0]        fin_exc, fin_eq;

   // Face cards share value 1 with aces; illegal codes map to value 0 and touch nothing.
   always_comb begin
      legal     = (card_q >= 4'd1) && (card_q <= 4'd13);
      value     = 4'd0;
      if (legal) value = (card_q >= 4'd11) ? 4'd1 : card_q;
      new_sum   = sum_q[player_q] + SW'(value);
      remain_w  = 8'sd21 - $signed({1'b0, new_sum});
      total_new = total_q;
      exc_cnt   = '0;
      eq_cnt    = '0;
      for (int v = 1; v <= 10; v++) begin
         cnt_new[v] = cnt_q[v];
         if (value == 4'(v) && cnt_q[v] != '0) begin
            cnt_new[v] = cnt_q[v] - CW'(1);
            total_new  = total_q - TW'(1);
         end
         if ($signed(8'(v)) > remain_w)  exc_cnt = exc_cnt + TW'(cnt_new[v]);
         if ($signed(8'(v)) == remain_w) eq_cnt  = cnt_new[v];
      end
      num_exc = NW'(exc_cnt) * NW'(100);
      num_eq  = NW'(eq_cnt) * NW'(100);
   end

   assign is_last = (player_q == PW'(N_PLAYERS - 1)) && (cidx_q == CIW'(CARDS_PER_PLAYER - 1));

   always_comb begin
      best     = '0;
      s        = '0;
      any      = 1'b0;
      tie      = 1'b0;
      winner_w = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         s = (PW'(p) == player_q) ? new_sum : sum_q[p];
         if (s <= SW'(21)) begin
            if (!any || s > best) begin
               best     = s;
               any      = 1'b1;
               tie      = 1'b0;
               winner_w = (PW+1)'(p + 1);
            end else if (s == best) begin
               tie = 1'b1;
            end
         end
      end
      if (tie) winner_w = '0;
   end

   // Restoring divider: step k tries total << (6-k), producing quotient bits MSB first.
   assign dsh    = RMW'(total_q) << (3'd6 - step_q);
   assign div_en = (total_q != '0);

   always_comb begin
      fin_exc = q_exc_q;
      fin_eq  = q_eq_q;
      if (remain_q <= 8'sd0) begin
         fin_exc = 7'd100;
         fin_eq  = 7'd0;
      end
      if (remain_q >= 8'sd10) fin_exc = 7'd0;
      if (remain_q < 8'sd1 || remain_q > 8'sd10) fin_eq = 7'd0;
      if (!div_en) begin
         fin_exc = 7'd0;
         fin_eq  = 7'd0;
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = UPDATE;
         UPDATE:  state_d = DIV;
         DIV:     if (step_q == 3'd7) state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == HOLD);
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         card_q <= '0;
         for (int v = 1; v <= 10; v++) cnt_q[v] <= (v == 1) ? CW'(16 * N_DECKS) : CW'(4 * N_DECKS);
         total_q <= TW'(TOT);
         for (int p = 0; p < N_PLAYERS; p++) sum_q[p] <= '0;
         player_q   <= '0;
         cidx_q     <= '0;
         round_q    <= '0;
         remain_q   <= '0;
         rem_exc_q  <= '0;
         rem_eq_q   <= '0;
         q_exc_q    <= '0;
         q_eq_q     <= '0;
         step_q     <= '0;
         err_q      <= 1'b0;
         last_q     <= 1'b0;
         winner_q   <= '0;
         out_exc_q  <= '0;
         out_eq_q   <= '0;
         out_err_q  <= 1'b0;
         out_last_q <= 1'b0;
         out_win_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) card_q <= in_card;
            UPDATE: begin
               for (int v = 1; v <= 10; v++) cnt_q[v] <= cnt_new[v];
               total_q         <= total_new;
               sum_q[player_q] <= new_sum;
               remain_q        <= remain_w;
               rem_exc_q       <= RMW'(num_exc);
               rem_eq_q        <= RMW'(num_eq);
               q_exc_q         <= '0;
               q_eq_q          <= '0;
               step_q          <= '0;
               err_q           <= !legal;
               last_q          <= is_last;
               winner_q        <= winner_w;
            end
            DIV: begin
               step_q <= step_q + 3'd1;
               if (step_q != 3'd7) begin
                  if (div_en && rem_exc_q >= dsh) begin
                     rem_exc_q <= rem_exc_q - dsh;
                     q_exc_q   <= {q_exc_q[5:0], 1'b1};
                  end else begin
                     q_exc_q   <= {q_exc_q[5:0], 1'b0};
                  end
                  if (div_en && rem_eq_q >= dsh) begin
                     rem_eq_q <= rem_eq_q - dsh;
                     q_eq_q   <= {q_eq_q[5:0], 1'b1};
                  end else begin
                     q_eq_q   <= {q_eq_q[5:0], 1'b0};
                  end
               end else begin
                  out_exc_q  <= fin_exc;
                  out_eq_q   <= fin_eq;
                  out_err_q  <= err_q;
                  out_last_q <= last_q;
                  out_win_q  <= last_q ? winner_q : '0;
               end
            end
            HOLD: if (out_ready) begin
               if (last_q) begin
                  for (int p = 0; p < N_PLAYERS; p++) sum_q[p] <= '0;
                  player_q <= '0;
                  cidx_q   <= '0;
                  // Shoe is refilled on the same edge the round counter wraps.
                  if (round_q == RW'(ROUNDS_PER_DECK - 1)) begin
                     round_q <= '0;
                     for (int v = 1; v <= 10; v++) cnt_q[v] <= (v == 1) ? CW'(16 * N_DECKS) : CW'(4 * N_DECKS);
                     total_q <= TW'(TOT);
                  end else begin
                     round_q <= round_q + RW'(1);
                  end
               end else if (cidx_q == CIW'(CARDS_PER_PLAYER - 1)) begin
                  cidx_q   <= '0;
                  player_q <= player_q + PW'(1);
               end else begin
                  cidx_q <= cidx_q + CIW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_player   = player_q;
   assign out_card_idx = cidx_q;
   assign out_exceed   = out_exc_q;
   assign out_equal    = out_eq_q;
   assign out_last     = out_last_q;
   assign out_winner   = out_win_q;
   assign out_err      = out_err_q;

endmodule

// File: tb/tb_blackjack_prob_engine.sv
// tb/tb_blackjack_prob_engine.sv - directed checks of blackjack_prob_engine at default parameters
module tb_blackjack_prob_engine;

   logic       clk1 = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_card = 4'd0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [0:0] out_player;
   logic [2:0] out_card_idx;
   logic [6:0] out_exceed;
   logic [6:0] out_equal;
   logic       out_last;
   logic [1:0] out_winner;
   logic       out_err;

   blackjack_prob_engine dut (
      .clk1         (clk1),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_card      (in_card),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_player   (out_player),
      .out_card_idx (out_card_idx),
      .out_exceed   (out_exceed),
      .out_equal    (out_equal),
      .out_last     (out_last),
      .out_winner   (out_winner),
      .out_err      (out_err)
   );

   always #5 clk1 = ~clk1;

   int n_cmp = 0;
   int n_mis = 0;
   int r_lat, r_exc, r_eq, r_last, r_win, r_err, r_pl, r_idx;

   // Rounds 2..5: P0 10,10,5 (25) vs P1 21; 18 vs 21; 23 vs 25; 5 vs 6.
   logic [3:0] tbl [4][10] = '{
      '{4'd10, 4'd10, 4'd5, 4'd14, 4'd14, 4'd6, 4'd6, 4'd4, 4'd5, 4'd14},
      '{4'd8,  4'd8,  4'd2, 4'd14, 4'd14, 4'd7, 4'd7, 4'd7, 4'd14, 4'd14},
      '{4'd8,  4'd8,  4'd7, 4'd14, 4'd14, 4'd10, 4'd9, 4'd6, 4'd14, 4'd14},
      '{4'd11, 4'd12, 4'd13, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2}
   };
   int exp_win [4] = '{2, 2, 0, 2};

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input logic [3:0] code);
      int n = 0;
      in_valid = 1'b1;
      in_card  = code;
      while (in_ready !== 1'b1 && n < 40) begin
         @(posedge clk1); #1;
         n++;
      end
      if (in_ready !== 1'b1) check_eq("accept_timeout", in_ready, 1);
      @(posedge clk1); #1;
      in_valid = 1'b0;
      in_card  = 4'd0;
   endtask

   task automatic wait_res();
      r_lat = 0;
      while (out_valid !== 1'b1 && r_lat < 40) begin
         @(posedge clk1); #1;
         r_lat++;
      end
      if (out_valid !== 1'b1) check_eq("result_timeout", out_valid, 1);
      r_exc  = out_exceed;
      r_eq   = out_equal;
      r_last = out_last;
      r_win  = out_winner;
      r_err  = out_err;
      r_pl   = out_player;
      r_idx  = out_card_idx;
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk1); #1;
      out_ready = 1'b0;
   endtask

   task automatic deal(input logic [3:0] code);
      send(code);
      wait_res();
      ack();
   endtask

   initial begin
      int bad;
      int seen;
      repeat (3) @(posedge clk1);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk1);
      #1;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_exceed", out_exceed, 0);
      check_eq("rst_equal", out_equal, 0);
      check_eq("rst_misc", {out_last, out_err, out_winner, out_player, out_card_idx}, 0);

      // Round 1: P0 10,9,bad,1,bad (20); P1 9,9,2,bad,bad (20) -> tie
      deal(4'd10);
      check_eq("c10_lat", r_lat, 9);
      check_eq("c10_exceed", r_exc, 0);
      check_eq("c10_equal", r_eq, 0);
      send(4'd9);
      wait_res();
      check_eq("c9_lat", r_lat, 9);
      check_eq("c9_exceed", r_exc, 60);
      check_eq("c9_equal", r_eq, 8);
      check_eq("c9_idx", r_idx, 1);
      check_eq("c9_err", r_err, 0);

      in_valid = 1'b1;
      in_card  = 4'd14;
      bad = 0;
      repeat (20) begin
         @(posedge clk1); #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_exceed != 7'd60 ||
             out_equal != 7'd8 || out_card_idx != 3'd1) bad++;
      end
      check_eq("bp_frozen", bad, 0);
      out_ready = 1'b1;
      @(posedge clk1); #1;
      out_ready = 1'b0;
      check_eq("bp_in_ready", in_ready, 1);
      @(posedge clk1); #1;
      in_valid = 1'b0;
      wait_res();
      ack();
      check_eq("bad_lat", r_lat, 9);
      check_eq("bad_err", r_err, 1);
      check_eq("bad_idx", r_idx, 2);
      check_eq("bad_exceed", r_exc, 60);
      check_eq("bad_equal", r_eq, 8);

      deal(4'd1);
      check_eq("c1_exceed", r_exc, 69);
      check_eq("c1_equal", r_eq, 30);
      deal(4'd14);
      check_eq("p0_end_idx", r_idx, 4);
      check_eq("p0_end_last", r_last, 0);
      deal(4'd9);
      check_eq("p1_first_player", r_pl, 1);
      check_eq("p1_first_idx", r_idx, 0);
      deal(4'd9);
      check_eq("p1_18_exceed", r_exc, 51);
      check_eq("p1_18_equal", r_eq, 8);
      deal(4'd2);
      deal(4'd14);
      deal(4'd14);
      check_eq("r1_last", r_last, 1);
      check_eq("r1_winner", r_win, 0);
      check_eq("r1_exceed", r_exc, 67);
      check_eq("r1_equal", r_eq, 32);
      check_eq("r1_player", r_pl, 1);

      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 10; c++) begin
            deal(tbl[r][c]);
            if (r == 0 && c == 0) check_eq("r2_first_exceed", r_exc + r_eq, 0);
            if (r == 0 && c == 2) begin
               check_eq("bust_exceed", r_exc, 100);
               check_eq("bust_equal", r_eq, 0);
            end
            if (c == 4) check_eq("mid_last", r_last, 0);
            if (c == 9) begin
               check_eq("round_last", r_last, 1);
               check_eq("round_winner", r_win, exp_win[r]);
            end
         end
      end

      // Sixth round starts on a refilled shoe
      deal(4'd10);
      check_eq("refill_c10", r_exc + r_eq, 0);
      deal(4'd9);
      check_eq("refill_exceed", r_exc, 60);
      check_eq("refill_equal", r_eq, 8);
      deal(4'd14);
      check_eq("refill_bad_err", r_err, 1);
      check_eq("refill_bad_exceed", r_exc, 60);
      check_eq("refill_bad_equal", r_eq, 8);

      send(4'd5);
      repeat (4) @(posedge clk1);
      #1 rst_n = 1'b0;
      @(posedge clk1);
      #1 rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(posedge clk1); #1;
         if (out_valid) seen++;
      end
      check_eq("abort_no_result", seen, 0);
      check_eq("abort_in_ready", in_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
